cmdbuilder: RTL and testbench
=============================

CMDBUILDER -- requirements
Module: cmdbuilder

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state updates on posedge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: start input 1 request pulse; cmd_type input 3 (0 QueryRep, 1 Ack, 2 Query, 3 QueryAdj, 4 Nack, 5 ReqRN, 6 Read, 7 reserved); bit_en input 1 one-clk bit strobe.
REQ-004 SHALL have field inputs: dr 1; m 2; trext 1; sel 2; session 2; target 1; q 4; updn 3; rn16 16; membank 2; wordptr 8; wordcnt 8.
REQ-005 SHALL have outputs: bitout 1 serial bit; bitvalid 1 one-clk pulse marking a new bitout; busy 1; done 1 one-clk pulse at end of frame; err 1 one-clk pulse on rejected request.

Function
REQ-006 SHALL transmit MSB-first frames: QueryRep 00+session (4 bits); Ack 01+rn16 (18); Query 1000+dr+m+trext+sel+session+target+q+CRC5 (22); QueryAdj 1001+session+updn (9); Nack 11000000 (8); ReqRN 11000001+rn16+CRC16 (40); Read 11000010+membank+wordptr+wordcnt+rn16+CRC16 (58).
REQ-007 SHALL implement states IDLE, SEND, CRC, FIN; IDLE->SEND on start with valid cmd_type; SEND->CRC after last payload bit when frame carries CRC, else SEND->FIN; CRC->FIN after last CRC bit; FIN->IDLE next clk.
REQ-008 SHALL latch all field inputs and cmd_type into a 58-bit shift register and a 6-bit length counter on the accepting clk edge; later input changes SHALL not affect the frame.
REQ-009 SHALL, in SEND/CRC, on each clk with bit_en=1, register the next bit into bitout and assert bitvalid for that single cycle; bit_en=0 cycles SHALL hold bitout and keep bitvalid=0.
REQ-010 SHALL not emit a bit on the same clk that accepts start; the first bit SHALL appear on the first subsequent bit_en.
REQ-011 SHALL compute CRC5 (x^5+x^3+1, preset 01001) over all Query bits preceding the CRC field and transmit the register MSB-first, uninverted.
REQ-012 SHALL compute CRC16 (x^16+x^12+x^5+1, preset FFFF) over all ReqRN/Read bits preceding the CRC field and transmit its ones-complement MSB-first.
REQ-013 SHALL assert busy from the accepting edge until the FIN->IDLE edge; done SHALL pulse in FIN.
REQ-014 SHALL ignore start while busy=1, with no err.
REQ-015 SHALL, on start in IDLE with cmd_type=7 (or a compiled-out type), pulse err for one clk and remain IDLE.
REQ-016 SHALL, when start and the final bit_en coincide, ignore start; a new request SHALL be accepted no earlier than the IDLE cycle.

Reset
REQ-017 SHALL, on reset low, immediately force IDLE, bitout=0, bitvalid=0, busy=0, done=0, err=0, counter=0, CRC registers to preset; reset mid-frame SHALL abort the frame with no done.
REQ-018 SHALL leave reset deassertion without side effects; no bit is emitted until a new start.

Configuration
REQ-019 SHALL support macro CMDBUILDER_READ_EN: defined -> Read (cmd_type 6) built as in REQ-006; undefined -> cmd_type 6 treated as invalid per REQ-015, and the shift register may shrink to 40 bits.

Verification
REQ-020 QueryRep, session=01 -> bits 0,0,0,1 on four bit_en pulses; done one clk after the 4th bitvalid; busy low after.
REQ-021 Ack, rn16=A5A5 -> 18 bits 01 1010010110100101; no CRC state entered.
REQ-022 Query, all fields 0 -> first 4 bits 1000, 22 bits total; the tag-side command parser reports crc5invalid=0 (CRC5 residue 00000).
REQ-023 ReqRN, rn16=1234 -> 40 bits; tag-side parser CRC16 residue 1D0F, crc16invalid=0; start pulsed mid-frame ignored, err=0.
REQ-024 Start with cmd_type=7 -> err pulse, busy stays 0; with CMDBUILDER_READ_EN undefined, cmd_type=6 -> same response.
REQ-025 Reset low after 10th bit of Read -> bitout=0, busy=0 immediately; new QueryRep after release transmits correctly.

Source files
------------

// File: rtl/cmdbuilder.sv
// cmdbuilder: serialises reader commands (QueryRep, Ack, Query, QueryAdj, Nack,
// ReqRN, Read) MSB-first. One bit is emitted per bit_en strobe, and CRC5 or CRC16
// is appended where the frame carries one.
// Optional feature macro: CMDBUILDER_READ_EN. When it is defined, the Read command
// (cmd_type 6) is built. When it is undefined, cmd_type 6 is rejected like type 7
// and the shift register shrinks to 40 bits.
module cmdbuilder (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  cmd_type,
  input  logic        bit_en,
  input  logic        dr,
  input  logic [1:0]  m,
  input  logic        trext,
  input  logic [1:0]  sel,
  input  logic [1:0]  session,
  input  logic        target,
  input  logic [3:0]  q,
  input  logic [2:0]  updn,
  input  logic [15:0] rn16,
  input  logic [1:0]  membank,
  input  logic [7:0]  wordptr,
  input  logic [7:0]  wordcnt,
  output logic        bitout,
  output logic        bitvalid,
  output logic        busy,
  output logic        done,
  output logic        err
);

`ifdef CMDBUILDER_READ_EN
  localparam int SR_W = 58;
`else
  localparam int SR_W = 40;
`endif

  localparam logic [4:0]  CRC5_PRESET  = 5'b01001;
  localparam logic [4:0]  CRC5_POLY    = 5'b01001;
  localparam logic [15:0] CRC16_PRESET = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY   = 16'h1021;

  typedef enum logic [1:0] {IDLE, SEND, CRC, FIN} state_t;
  typedef enum logic [1:0] {CRC_NONE, CRC_5, CRC_16} crc_kind_t;

  state_t            r_state;
  crc_kind_t         r_kind;
  logic [SR_W-1:0]   r_sr;
  logic [5:0]        r_cnt;
  logic [4:0]        r_crc5;
  logic [15:0]       r_crc16;

  logic [SR_W-1:0]   w_load;
  logic [5:0]        w_len;
  crc_kind_t         w_kind;
  logic              w_valid;
  logic              w_bit;
  logic [4:0]        w_crc5_nxt;
  logic [15:0]       w_crc16_nxt;

`ifndef CMDBUILDER_READ_EN
  // Read fields have no consumer when Read is compiled out
  logic w_unused_rd;
  assign w_unused_rd = ^{membank, wordptr, wordcnt};
`endif

  // Decode the requested command into a left-aligned payload, its length and CRC kind
  always_comb begin
    w_load  = '0;
    w_len   = '0;
    w_kind  = CRC_NONE;
    w_valid = 1'b0;
    case (cmd_type)
      3'd0: begin
        w_valid = 1'b1;
        w_len   = 6'd4;
        w_load[SR_W-1 -: 4] = {2'b00, session};
      end
      3'd1: begin
        w_valid = 1'b1;
        w_len   = 6'd18;
        w_load[SR_W-1 -: 18] = {2'b01, rn16};
      end
      3'd2: begin
        w_valid = 1'b1;
        w_len   = 6'd17;
        w_kind  = CRC_5;
        w_load[SR_W-1 -: 17] = {4'b1000, dr, m, trext, sel, session, target, q};
      end
      3'd3: begin
        w_valid = 1'b1;
        w_len   = 6'd9;
        w_load[SR_W-1 -: 9] = {4'b1001, session, updn};
      end
      3'd4: begin
        w_valid = 1'b1;
        w_len   = 6'd8;
        w_load[SR_W-1 -: 8] = 8'b1100_0000;
      end
      3'd5: begin
        w_valid = 1'b1;
        w_len   = 6'd24;
        w_kind  = CRC_16;
        w_load[SR_W-1 -: 24] = {8'b1100_0001, rn16};
      end
`ifdef CMDBUILDER_READ_EN
      3'd6: begin
        w_valid = 1'b1;
        w_len   = 6'd42;
        w_kind  = CRC_16;
        w_load[SR_W-1 -: 42] = {8'b1100_0010, membank, wordptr, wordcnt, rn16};
      end
`endif
      default: ;
    endcase
  end

  // Serial CRC update driven by the payload bit about to leave the shift register
  assign w_bit       = r_sr[SR_W-1];
  assign w_crc5_nxt  = {r_crc5[3:0], 1'b0} ^ ((w_bit ^ r_crc5[4]) ? CRC5_POLY : 5'b0);
  assign w_crc16_nxt = {r_crc16[14:0], 1'b0} ^ ((w_bit ^ r_crc16[15]) ? CRC16_POLY : 16'h0);

  // Frame FSM: latch on accept, shift payload then CRC on bit_en, finish with a done pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_kind   <= CRC_NONE;
      r_sr     <= '0;
      r_cnt    <= '0;
      r_crc5   <= CRC5_PRESET;
      r_crc16  <= CRC16_PRESET;
      bitout   <= 1'b0;
      bitvalid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      bitvalid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (w_valid) begin
              r_sr    <= w_load;
              r_cnt   <= w_len;
              r_kind  <= w_kind;
              r_crc5  <= CRC5_PRESET;
              r_crc16 <= CRC16_PRESET;
              busy    <= 1'b1;
              r_state <= SEND;
            end else begin
              err <= 1'b1;
            end
          end
        end
        SEND: begin
          if (bit_en) begin
            bitout   <= w_bit;
            bitvalid <= 1'b1;
            r_sr     <= {r_sr[SR_W-2:0], 1'b0};
            r_crc5   <= w_crc5_nxt;
            r_crc16  <= w_crc16_nxt;
            if (r_cnt == 6'd1) begin
              case (r_kind)
                CRC_5: begin
                  r_cnt   <= 6'd5;
                  r_state <= CRC;
                end
                CRC_16: begin
                  r_cnt   <= 6'd16;
                  r_state <= CRC;
                end
                default: begin
                  r_cnt   <= '0;
                  r_state <= FIN;
                end
              endcase
            end else begin
              r_cnt <= r_cnt - 6'd1;
            end
          end
        end
        CRC: begin
          // CRC5 goes out as-is, CRC16 goes out ones-complemented
          if (bit_en) begin
            bitout   <= (r_kind == CRC_16) ? ~r_crc16[15] : r_crc5[4];
            bitvalid <= 1'b1;
            r_crc5   <= {r_crc5[3:0], 1'b0};
            r_crc16  <= {r_crc16[14:0], 1'b0};
            if (r_cnt == 6'd1) begin
              r_cnt   <= '0;
              r_state <= FIN;
            end else begin
              r_cnt <= r_cnt - 6'd1;
            end
          end
        end
        FIN: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmdbuilder.sv
// Randomised self-checking bench for cmdbuilder. The reference frames are built
// directly from the command bit layouts, with bitwise CRCs over a queue.
module tb_cmdbuilder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, bit_en;
  logic [2:0]  cmd_type;
  logic        dr, trext, target;
  logic [1:0]  m, sel, session, membank;
  logic [3:0]  q;
  logic [2:0]  updn;
  logic [15:0] rn16;
  logic [7:0]  wordptr, wordcnt;
  logic        bitout, bitvalid, busy, done, err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        dr;
    logic [1:0]  m;
    logic        trext;
    logic [1:0]  sel;
    logic [1:0]  session;
    logic        target;
    logic [3:0]  q;
    logic [2:0]  updn;
    logic [15:0] rn16;
    logic [1:0]  membank;
    logic [7:0]  wordptr;
    logic [7:0]  wordcnt;
  } fld_t;

  bit exp_q[$];
  bit rx_q[$];

  cmdbuilder dut (
    .clk(clk), .reset(reset), .start(start), .cmd_type(cmd_type), .bit_en(bit_en),
    .dr(dr), .m(m), .trext(trext), .sel(sel), .session(session), .target(target),
    .q(q), .updn(updn), .rn16(rn16), .membank(membank), .wordptr(wordptr),
    .wordcnt(wordcnt), .bitout(bitout), .bitvalid(bitvalid), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic fld_t rand_fields();
    fld_t f;
    f.dr = 1'($urandom); f.m = 2'($urandom); f.trext = 1'($urandom);
    f.sel = 2'($urandom); f.session = 2'($urandom); f.target = 1'($urandom);
    f.q = 4'($urandom); f.updn = 3'($urandom); f.rn16 = 16'($urandom);
    f.membank = 2'($urandom); f.wordptr = 8'($urandom); f.wordcnt = 8'($urandom);
    return f;
  endfunction

  task automatic drive_fields(input fld_t f);
    dr = f.dr; m = f.m; trext = f.trext; sel = f.sel; session = f.session;
    target = f.target; q = f.q; updn = f.updn; rn16 = f.rn16;
    membank = f.membank; wordptr = f.wordptr; wordcnt = f.wordcnt;
  endtask

  task automatic push_bits(input logic [63:0] v, input int w);
    for (int i = w - 1; i >= 0; i--) exp_q.push_back(v[i]);
  endtask

  function automatic logic [4:0] crc5_q(input bit b[$]);
    logic [4:0] c = 5'b01001;
    foreach (b[i]) begin
      logic fb = b[i] ^ c[4];
      c = {c[3:0], 1'b0};
      if (fb) c = c ^ 5'b01001;
    end
    return c;
  endfunction

  function automatic logic [15:0] crc16_q(input bit b[$]);
    logic [15:0] c = 16'hFFFF;
    foreach (b[i]) begin
      logic fb = b[i] ^ c[15];
      c = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  // Reference frame straight from the command layouts
  task automatic build_frame(input int t, input fld_t f);
    exp_q.delete();
    case (t)
      0: begin push_bits(2'b00, 2); push_bits(f.session, 2); end
      1: begin push_bits(2'b01, 2); push_bits(f.rn16, 16); end
      2: begin
        push_bits(4'b1000, 4); push_bits(f.dr, 1); push_bits(f.m, 2); push_bits(f.trext, 1);
        push_bits(f.sel, 2); push_bits(f.session, 2); push_bits(f.target, 1); push_bits(f.q, 4);
        push_bits(crc5_q(exp_q), 5);
      end
      3: begin push_bits(4'b1001, 4); push_bits(f.session, 2); push_bits(f.updn, 3); end
      4: push_bits(8'b1100_0000, 8);
      5: begin
        push_bits(8'b1100_0001, 8); push_bits(f.rn16, 16);
        push_bits(~crc16_q(exp_q), 16);
      end
      default: begin
        push_bits(8'b1100_0010, 8); push_bits(f.membank, 2); push_bits(f.wordptr, 8);
        push_bits(f.wordcnt, 8); push_bits(f.rn16, 16);
        push_bits(~crc16_q(exp_q), 16);
      end
    endcase
  endtask

  // Issue a request with bit_en high on the accepting edge, then scramble the inputs
  task automatic start_cmd(input int t, input fld_t f);
    build_frame(t, f);
    drive_fields(f);
    cmd_type = 3'(t);
    start = 1'b1;
    bit_en = 1'b1;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b1 || bitvalid !== 1'b0)
      $display("FAIL accept t=%0d: busy=%0b bitvalid=%0b want busy=1 bitvalid=0", t, busy, bitvalid);
    if (busy !== 1'b1 || bitvalid !== 1'b0) bad++;
    start = 1'b0;
    bit_en = 1'b0;
    drive_fields(rand_fields());
    cmd_type = 3'($urandom);
  endtask

  // Clock the frame out under random bit_en and check every cycle against the model
  task automatic run_frame(input string nm, input int en_pct, input bit poke, input int abort_at);
    int cyc = 0;
    int last_bv = -1;
    int done_cyc = -1;
    bit en, exp_bv;
    logic prev_out;
    rx_q.delete();
    prev_out = bitout;
    while (done_cyc < 0 && cyc < 3000) begin
      en = ($urandom_range(0, 99) < en_pct);
      bit_en = en;
      start = 1'b0;
      if (poke && busy && ($urandom_range(0, 5) == 0 ||
                           (en && rx_q.size() == exp_q.size() - 1))) begin
        start = 1'b1;
        cmd_type = 3'($urandom_range(0, 5));
      end
      exp_bv = en && (rx_q.size() < exp_q.size());
      @(posedge clk); #1;
      cyc++;
      total++;
      if (bitvalid !== exp_bv) begin
        bad++;
        $display("FAIL %s bitvalid cyc=%0d: got %0b want %0b", nm, cyc, bitvalid, exp_bv);
      end
      if (bitvalid === 1'b1) begin
        rx_q.push_back(bitout);
        last_bv = cyc;
      end else begin
        total++;
        if (bitout !== prev_out) begin
          bad++;
          $display("FAIL %s bitout_hold cyc=%0d: got %0b want %0b", nm, cyc, bitout, prev_out);
        end
      end
      prev_out = bitout;
      total++;
      if (err !== 1'b0) begin
        bad++;
        $display("FAIL %s err cyc=%0d: got %0b want 0", nm, cyc, err);
      end
      if (done === 1'b1) begin
        done_cyc = cyc;
        total++;
        if (busy !== 1'b0) begin
          bad++;
          $display("FAIL %s busy_at_done: got %0b want 0", nm, busy);
        end
      end
      if (abort_at > 0 && rx_q.size() == abort_at) begin
        start = 1'b0;
        reset = 1'b0;
        #1;
        total++;
        if ({bitout, bitvalid, busy, done, err} !== 5'b0) begin
          bad++;
          $display("FAIL %s abort_reset: got out/vld/busy/done/err=%05b want 00000",
                   nm, {bitout, bitvalid, busy, done, err});
        end
        for (int i = 0; i < abort_at; i++) begin
          total++;
          if (rx_q[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL %s abort_prefix bit %0d: got %0b want %0b", nm, i, rx_q[i], exp_q[i]);
          end
        end
        return;
      end
    end
    start = 1'b0;
    bit_en = 1'b0;
    total++;
    if (done_cyc < 0) begin
      bad++;
      $display("FAIL %s timeout: got no done want done within 3000 cycles", nm);
    end
    total++;
    if (rx_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL %s length: got %0d want %0d", nm, rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      total++;
      if (rx_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL %s bit %0d: got %0b want %0b", nm, i, rx_q[i], exp_q[i]);
      end
    end
    total++;
    if (done_cyc != last_bv + 1) begin
      bad++;
      $display("FAIL %s done_timing: got cyc %0d want %0d", nm, done_cyc, last_bv + 1);
    end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s after_done: got done=%0b busy=%0b want 0 0", nm, done, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bit_en = 1'b1;
    start = 1'b1;
    cmd_type = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({bitout, bitvalid, busy, done, err} !== 5'b0) begin
      bad++;
      $display("FAIL reset_state: got out/vld/busy/done/err=%05b want 00000",
               {bitout, bitvalid, busy, done, err});
    end
    start = 1'b0;
    reset = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      total++;
      if (bitvalid !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_release: got bitvalid=%0b busy=%0b want 0 0", bitvalid, busy);
      end
    end
    bit_en = 1'b0;
  endtask

  task automatic test_queryrep();
    fld_t f = rand_fields();
    logic [3:0] got;
    f.session = 2'b01;
    start_cmd(0, f);
    run_frame("queryrep", 100, 1'b0, 0);
    got = {rx_q[0], rx_q[1], rx_q[2], rx_q[3]};
    total++;
    if (got !== 4'b0001) begin
      bad++;
      $display("FAIL queryrep_bits: got %b want 0001", got);
    end
  endtask

  task automatic test_ack();
    fld_t f = rand_fields();
    f.rn16 = 16'hA5A5;
    start_cmd(1, f);
    run_frame("ack", 60, 1'b0, 0);
  endtask

  task automatic test_query();
    fld_t f = '{default: '0};
    start_cmd(2, f);
    run_frame("query", 70, 1'b0, 0);
    total++;
    if (crc5_q(rx_q) !== 5'b00000) begin
      bad++;
      $display("FAIL query_crc5_residue: got %b want 00000", crc5_q(rx_q));
    end
  endtask

  task automatic test_reqrn();
    fld_t f = rand_fields();
    f.rn16 = 16'h1234;
    start_cmd(5, f);
    run_frame("reqrn", 50, 1'b1, 0);
    total++;
    if (crc16_q(rx_q) !== 16'h1D0F) begin
      bad++;
      $display("FAIL reqrn_crc16_residue: got %h want 1d0f", crc16_q(rx_q));
    end
  endtask

  task automatic check_invalid(input int t);
    cmd_type = 3'(t);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL invalid_t%0d: got err=%0b busy=%0b want 1 0", t, err, busy);
    end
    @(posedge clk); #1;
    total++;
    if (err !== 1'b0 || busy !== 1'b0 || bitvalid !== 1'b0) begin
      bad++;
      $display("FAIL invalid_t%0d_after: got err=%0b busy=%0b vld=%0b want 0 0 0",
               t, err, busy, bitvalid);
    end
  endtask

  task automatic test_invalid();
    check_invalid(7);
`ifndef CMDBUILDER_READ_EN
    check_invalid(6);
`endif
  endtask

  task automatic test_abort();
    fld_t f = rand_fields();
`ifdef CMDBUILDER_READ_EN
    start_cmd(6, f);
`else
    start_cmd(5, f);
`endif
    run_frame("abort", 80, 1'b0, 10);
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_hold: got done=%0b busy=%0b want 0 0", done, busy);
    end
    reset = 1'b1;
    bit_en = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      total++;
      if (bitvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        bad++;
        $display("FAIL abort_release: got vld=%0b busy=%0b done=%0b want 0 0 0",
                 bitvalid, busy, done);
      end
    end
    bit_en = 1'b0;
    f = rand_fields();
    start_cmd(0, f);
    run_frame("post_abort_queryrep", 100, 1'b0, 0);
  endtask

  task automatic test_random();
    int t;
`ifdef CMDBUILDER_READ_EN
    int tmax = 6;
`else
    int tmax = 5;
`endif
    for (int i = 0; i < 25; i++) begin
      t = $urandom_range(0, tmax);
      start_cmd(t, rand_fields());
      run_frame($sformatf("random%0d_t%0d", i, t), $urandom_range(20, 100),
                1'($urandom), 0);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; bit_en = 1'b0; cmd_type = 3'd0;
    drive_fields('{default: '0});
    test_reset();
    test_queryrep();
    test_ack();
    test_query();
    test_reqrn();
    test_invalid();
    test_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
